// File: rtl/load_store_unit.sv
// Data-memory initiator: turns one MEM-stage load/store into a word-aligned req/ack
// transaction, with lane steering, load extension and error completion.
module load_store_unit #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [DM_ADDRESS-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  m_req_o,
  output logic                  m_we_o,
  output logic [DM_ADDRESS-1:0] m_addr_o,
  output logic [3:0]            m_be_o,
  output logic [DATA_W-1:0]     m_wdata_o,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic                  m_ack_i
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  illegal;
  logic                  f3_legal;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [DATA_W-1:0]     lane_wdata;
  logic [DATA_W-1:0]     shifted;
  logic [DATA_W-1:0]     load_data;

  // Both mem_read and mem_write set is accepted so it can complete as illegal.
  assign accept = (state_q == StIdle) && req_valid_i && (mem_read_i || mem_write_i);

  always_comb begin
    f3_legal = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  end

  assign illegal = (mem_read_i && mem_write_i) || !f3_legal ||
                   (mem_write_i && funct3_i[2]) ||
                   ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  assign lane = addr_q[1:0];

  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << lane;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  assign shifted = m_rdata_i >> {lane, 3'b000};

  always_comb begin
    load_data = m_rdata_i;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data = m_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d     = mem_write_i;
          funct3_d = funct3_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          timer_d  = '0;
          rdata_d  = '0;
          err_d    = illegal;
          state_d  = illegal ? StResp : StReq;
        end
      end
      StReq: begin
        if (m_ack_i) begin
          rdata_d = we_q ? '0 : load_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        timer_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      timer_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory-side outputs are gated by state so they read zero outside a request.
  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = (state_q == StResp) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == StResp) && err_q;
  assign m_req_o     = (state_q == StReq);
  assign m_we_o      = (state_q == StReq) && we_q;
  assign m_addr_o    = (state_q == StReq) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
  assign m_be_o      = ((state_q == StReq) && we_q) ? be : 4'b0000;
  assign m_wdata_o   = ((state_q == StReq) && we_q) ? lane_wdata : '0;

endmodule
